// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage core (load-use, redirect, divider, bus wait).
// Optional stall-cycle counter is built only when PIPE_CTRL_STALL_CNT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DIV_TMO = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_nop,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              div_start,
    input  logic              div_done,
    input  logic              mem_wait,
    output logic              pc_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic              ex_mem_hold,
    output logic              mem_wb_flush,
    output logic              div_err,
    output logic [31:0]       stall_cnt
);

    localparam int unsigned TmoW = (DIV_TMO > 2) ? $clog2(DIV_TMO) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(DIV_TMO - 1);

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StLuBubble = 2'd1;
    localparam logic [1:0] StDivWait  = 2'd2;
    localparam logic [1:0] StBusWait  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [1:0]      ret_q, ret_d;
    logic [1:0]      cur_state;
    logic [TmoW-1:0] tmo_q, tmo_d;

    // While parked in BUS_WAIT, the saved state's rules apply as soon as the bus frees up.
    assign cur_state = (state_q == StBusWait) ? ret_q : state_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        tmo_d        = tmo_q;
        pc_hold      = 1'b0;
        pc_load      = 1'b0;
        pc_target    = '0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_flush = 1'b0;
        div_err      = 1'b0;

        if (mem_wait) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = StBusWait;
            ret_d        = (cur_state == StDivWait) ? StDivWait : StRun;
        end else begin
            case (cur_state)
                StRun: begin
                    if (div_start) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                        tmo_d       = '0;
                        state_d     = StDivWait;
                    end else if (jump_req) begin
                        pc_load     = 1'b1;
                        pc_target   = jump_addr;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = StRun;
                    end else if (ld_nop) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = StLuBubble;
                    end else begin
                        state_d = StRun;
                    end
                end
                StLuBubble: begin
                    // A second ld_nop here is the same hazard already covered by the bubble.
                    if (jump_req) begin
                        pc_load     = 1'b1;
                        pc_target   = jump_addr;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    state_d = StRun;
                end
                StDivWait: begin
                    if (div_done) begin
                        state_d = StRun;
                    end else if (tmo_q == TmoLast) begin
                        div_err = 1'b1;
                        state_d = StRun;
                    end else begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                        tmo_d       = tmo_q + 1'b1;
                        state_d     = StDivWait;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end

        // Outputs take their reset values as soon as rst_n drops, not at the next edge.
        if (!rst_n) begin
            pc_hold      = 1'b0;
            pc_load      = 1'b0;
            pc_target    = '0;
            if_id_hold   = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_hold   = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_hold  = 1'b0;
            mem_wb_flush = 1'b1;
            div_err      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            ret_q   <= StRun;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table, hand-written corner sequences and a randomized run
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DIV_TMO = 64;

    // {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
    //  ex_mem_hold, mem_wb_flush, div_err}
    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_RST  = 9'b000101010;
    localparam logic [8:0] O_LU   = 9'b101001000;
    localparam logic [8:0] O_JMP  = 9'b010101000;
    localparam logic [8:0] O_DIV  = 9'b101010100;
    localparam logic [8:0] O_BUS  = 9'b101010110;
    localparam logic [8:0] O_ERR  = 9'b000000001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_nop, jump_req, div_start, div_done, mem_wait;
    logic [ADDR_W-1:0] jump_addr;
    logic              pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic              ex_mem_hold, mem_wb_flush, div_err;
    logic [ADDR_W-1:0] pc_target;
    logic [31:0]       stall_cnt;
    logic [8:0]        act;

    int nvec = 0;
    int nbad = 0;

    // Behavioural model: divider in flight, cycles since it started, bubble just issued.
    bit          m_busy     = 1'b0;
    int          m_age      = 0;
    bit          m_after_lu = 1'b0;
    int unsigned m_stalls   = 0;

    typedef struct packed {
        logic        r;
        logic        ln;
        logic        jr;
        logic [31:0] ja;
        logic        ds;
        logic        dd;
        logic        mw;
        logic [8:0]  e;
        logic [31:0] t;
    } vec_t;

    vec_t tbl[$];

    pipe_ctrl #(.ADDR_W(ADDR_W), .DIV_TMO(DIV_TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_nop      (ld_nop),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .div_start   (div_start),
        .div_done    (div_done),
        .mem_wait    (mem_wait),
        .pc_hold     (pc_hold),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .if_id_hold  (if_id_hold),
        .if_id_flush (if_id_flush),
        .id_ex_hold  (id_ex_hold),
        .id_ex_flush (id_ex_flush),
        .ex_mem_hold (ex_mem_hold),
        .mem_wb_flush(mem_wb_flush),
        .div_err     (div_err),
        .stall_cnt   (stall_cnt)
    );

    assign act = {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                  ex_mem_hold, mem_wb_flush, div_err};

    always #5 clk = ~clk;

    // Both come from EX, so they can never coincide.
    always @(posedge clk) begin
        assert (!(rst_n && div_start && jump_req)) else $error("div_start with jump_req");
    end

    function automatic vec_t mk(logic r, logic ln, logic jr, logic [31:0] ja, logic ds,
                                logic dd, logic mw, logic [8:0] e, logic [31:0] t);
        vec_t v;
        v.r = r; v.ln = ln; v.jr = jr; v.ja = ja; v.ds = ds; v.dd = dd; v.mw = mw;
        v.e = e; v.t = t;
        return v;
    endfunction

    task automatic model(output logic [8:0] e, output logic [31:0] tgt);
        bit lu_next;
        lu_next = 1'b0;
        e       = O_IDLE;
        tgt     = '0;
        if (!rst_n) begin
            e          = O_RST;
            m_busy     = 1'b0;
            m_age      = 0;
            m_after_lu = 1'b0;
            m_stalls   = 0;
            return;
        end
        if (mem_wait) begin
            e = O_BUS;
        end else if (m_busy) begin
            if (div_done) begin
                m_busy = 1'b0;
            end else if (m_age == DIV_TMO) begin
                e      = O_ERR;
                m_busy = 1'b0;
            end else begin
                e     = O_DIV;
                m_age = m_age + 1;
            end
        end else if (div_start && !m_after_lu) begin
            e      = O_DIV;
            m_busy = 1'b1;
            m_age  = 1;
        end else if (jump_req) begin
            e   = O_JMP;
            tgt = jump_addr;
        end else if (ld_nop && !m_after_lu) begin
            e       = O_LU;
            lu_next = 1'b1;
        end
        m_after_lu = lu_next;
        if (e[8]) m_stalls = m_stalls + 1;
    endtask

    task automatic step(input logic r, input logic ln, input logic jr, input logic [31:0] ja,
                        input logic ds, input logic dd, input logic mw,
                        output logic [8:0] e, output logic [31:0] tgt, output logic [31:0] es);
        @(negedge clk);
        rst_n = r; ld_nop = ln; jump_req = jr; jump_addr = ja;
        div_start = ds; div_done = dd; mem_wait = mw;
        #1;
`ifdef PIPE_CTRL_STALL_CNT_EN
        es = r ? m_stalls : 32'd0;
`else
        es = 32'd0;
`endif
        model(e, tgt);
    endtask

    task automatic check(input string name, input logic [8:0] e, input logic [31:0] tgt);
        nvec++;
        if (act !== e || pc_target !== tgt) begin
            nbad++;
            $display("FAIL %s: got outputs=%b target=%h, required outputs=%b target=%h",
                     name, act, pc_target, e, tgt);
        end
    endtask

    task automatic check_stall(input string name, input logic [31:0] es);
        nvec++;
        if (stall_cnt !== es) begin
            nbad++;
            $display("FAIL %s: got stall_cnt=%0d, required %0d", name, stall_cnt, es);
        end
    endtask

    initial begin
        logic [8:0]  e;
        logic [31:0] tgt, es, exp_stall;
        logic        r, ln, jr, ds, dd, mw;
        logic [31:0] ja;

        rst_n = 1'b0; ld_nop = 1'b0; jump_req = 1'b0; jump_addr = '0;
        div_start = 1'b0; div_done = 1'b0; mem_wait = 1'b0;

        //               r  ln jr addr       ds dd mw exp     target
        tbl.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0, O_RST,  32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0, 0, 0, O_LU,   32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0, 0, 0, O_LU,   32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h100,   0, 0, 0, O_JMP,  32'h100));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0, 0, 0, O_LU,   32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h200,   0, 0, 0, O_JMP,  32'h200));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     1, 0, 0, O_DIV,  32'h0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, O_DIV, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 1, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     1, 0, 0, O_DIV,  32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_DIV,  32'h0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, O_BUS, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_DIV,  32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 1, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     1, 0, 0, O_DIV,  32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_DIV,  32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0, O_RST,  32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 1, 0, O_IDLE, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h300,   0, 0, 1, O_BUS,  32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0, 0, 0, O_LU,   32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, O_IDLE, 32'h0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].ln, tbl[i].jr, tbl[i].ja, tbl[i].ds, tbl[i].dd, tbl[i].mw,
                 e, tgt, es);
            check($sformatf("tbl%0d", i), tbl[i].e, tbl[i].t);
        end

        // Divider timeout: holds for DIV_TMO cycles, error pulse on the next.
        step(1, 0, 0, 0, 1, 0, 0, e, tgt, es);
        check("tmo_start", O_DIV, 32'h0);
        for (int i = 1; i < DIV_TMO; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
            check($sformatf("tmo_hold%0d", i), O_DIV, 32'h0);
        end
        step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
        check("tmo_err", O_ERR, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
        check("tmo_after", O_IDLE, 32'h0);

        // Stall counter: one load-use bubble plus a five-cycle divide.
        step(0, 0, 0, 0, 0, 0, 0, e, tgt, es);
        check("sc_rst", O_RST, 32'h0);
        check_stall("sc_rst_cnt", 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
        step(1, 1, 0, 0, 0, 0, 0, e, tgt, es);
        check("sc_lu", O_LU, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
        step(1, 0, 0, 0, 1, 0, 0, e, tgt, es);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
        step(1, 0, 0, 0, 0, 1, 0, e, tgt, es);
        check("sc_done", O_IDLE, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, e, tgt, es);
`ifdef PIPE_CTRL_STALL_CNT_EN
        exp_stall = 32'd6;
`else
        exp_stall = 32'd0;
`endif
        check_stall("sc_total", exp_stall);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            mw = ($urandom_range(0, 6) == 0);
            ln = ($urandom_range(0, 3) == 0);
            jr = ($urandom_range(0, 6) == 0);
            ds = !jr && ($urandom_range(0, 14) == 0);
            dd = ($urandom_range(0, 19) == 0);
            ja = $urandom;
            step(r, ln, jr, ja, ds, dd, mw, e, tgt, es);
            check($sformatf("rnd%0d", i), e, tgt);
            check_stall($sformatf("rnd%0d_cnt", i), es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage core. It consumes hazard and request signals and drives per-stage hold/flush controls plus the PC redirect:
- load-use bubble request from hazard detection
- branch/jump redirect from EX
- multi-cycle divider busy
- data-bus wait
It sits between hazard detection, EX, the divider and the pipeline registers. It turns single-cycle detection pulses into correctly sequenced bubbles.

Parameters:
- ADDR_W, 32, PC/jump address width
- DIV_TMO, 64, max DIV_WAIT cycles before div_err pulse (must be ≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ld_nop  in  1  load-use hazard from hazard detection (ID needs EX load result)
- jump_req  in  1  EX resolved taken branch/jump
- jump_addr  in  ADDR_W  redirect target
- div_start  in  1  divide instruction entering EX this cycle
- div_done  in  1  divider result valid (1-cycle pulse)
- mem_wait  in  1  data bus not ready, MEM stage must hold
- pc_hold  out  1  PC keeps value
- pc_load  out  1  PC loads pc_target
- pc_target  out  ADDR_W  redirect address
- if_id_hold  out  1  IF/ID register holds
- if_id_flush  out  1  IF/ID register loads NOP
- id_ex_hold  out  1  ID/EX register holds
- id_ex_flush  out  1  ID/EX register loads NOP
- ex_mem_hold  out  1  EX/MEM register holds
- mem_wb_flush  out  1  MEM/WB loads NOP (bubble behind stalled MEM)
- div_err  out  1  1-cycle pulse on divider timeout
- stall_cnt  out  32  total stall cycles (see optional feature)

Behaviour:
- Async reset (rst_n low): state=RUN, counters=0. Flush outputs=1, all holds=0, pc_load=0, pc_target=0, div_err=0.
- Outputs are combinational from state and current inputs (same-cycle response, zero latency). State and counters update on rising clk.
- States: RUN, LU_BUBBLE, DIV_WAIT, BUS_WAIT.
- Priority in every state: mem_wait > divider hold > jump_req > ld_nop.
- mem_wait=1 (any state):
  - pc_hold, if_id_hold, id_ex_hold, ex_mem_hold =1; mem_wb_flush=1.
  - jump_req and ld_nop are ignored; pc_load=0.
  - State -> BUS_WAIT, latching the state to return to (RUN or DIV_WAIT).
- BUS_WAIT: the first cycle with mem_wait=0 returns to the saved state and applies that state's normal rules in the same cycle.
- RUN, div_start=1: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold =1; -> DIV_WAIT; timeout counter cleared.
- DIV_WAIT:
  - Holds as above while div_done=0.
  - Cycle with div_done=1: all holds released, ex_mem accepts result, -> RUN.
  - Timeout counter reaching DIV_TMO-1 without div_done: div_err pulse, holds released, -> RUN.
- RUN, jump_req=1:
  - pc_load=1, pc_target=jump_addr, if_id_flush=1, id_ex_flush=1.
  - ld_nop in the same cycle is ignored (wrong-path instruction). State stays RUN.
- RUN, ld_nop=1, no jump:
  - pc_hold=1, if_id_hold=1, id_ex_flush=1; -> LU_BUBBLE.
- LU_BUBBLE:
  - ld_nop is ignored, giving exactly one bubble per load-use.
  - jump_req honoured as in RUN.
  - Always -> RUN next cycle unless mem_wait.
- div_start together with jump_req in RUN: impossible by construction (both are EX). Divider wins; bench asserts this never occurs.
- div_done while in RUN: ignored.
- Reset mid-stall: immediate return to the reset values above.

Optional Feature:
- Macro: PIPE_CTRL_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every clock where pc_hold=1, saturating at 0xFFFFFFFF. Reset to 0.
- Not defined: stall_cnt tied to 0 and no counter flops.

Test Plan:
- ld_nop pulse 1 cycle in RUN -> exactly one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1; RUN after 1 cycle. ld_nop held 2 cycles -> still only 1 bubble.
- jump_req=1, jump_addr=0x0000_0100 with ld_nop=1 same cycle -> pc_load=1, pc_target=0x100, both flushes=1, pc_hold=0, state RUN.
- div_start, div_done 5 cycles later -> holds=1 for 5 cycles, released on the done cycle. No done for 64 cycles -> div_err pulse at cycle 64, holds drop.
- mem_wait=1 for 3 cycles during DIV_WAIT -> all holds + mem_wb_flush for 3 cycles, then back in DIV_WAIT; div_done afterwards still releases.
- rst_n low during DIV_WAIT -> outputs immediately at reset values; after release, state RUN with no holds.
- With PIPE_CTRL_STALL_CNT_EN: 1 load-use + 5-cycle div -> stall_cnt=6. Without the macro -> stall_cnt=0.
